// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg: shared nibble width and sequencer state encoding
package cla_seq_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/four_bit_carry_lookahead_adder.sv
// four_bit_carry_lookahead_adder: 4-bit adder with flattened generate/propagate carry lookahead
module four_bit_carry_lookahead_adder (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = X & Y;
  assign p = X ^ Y;
  assign c[0] = Ci;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign S  = p ^ c[3:0];
  assign Co = c[4];
endmodule

// File: rtl/cla_word_adder_sequencer.sv
// cla_word_adder_sequencer: word-width add by reusing one 4-bit CLA, one nibble per clock, LSB first
module cla_word_adder_sequencer
  import cla_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NIBBLES-1:0]    a,
  input  logic [4*NIBBLES-1:0]    b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NIBBLES-1:0]    sum,
  output logic                    cout,
  output logic                    ovf
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  seq_state_t state_q;
  logic [W-1:0] a_q, b_q, acc_q, sum_q;
  logic [W+3:0] acc_cat;
  logic [W-1:0] acc_d;
  logic [IW-1:0] idx_q;
  logic c_q, cout_q, ovf_q, co, last, ovf_d;
  logic [3:0] s;
  four_bit_carry_lookahead_adder u_cla (a_q[3:0], b_q[3:0], c_q, s, co);
  assign acc_cat = {s, acc_q};
  assign acc_d   = acc_cat[W+3:4];
  assign last    = idx_q == IW'(NIBBLES - 1);
  // On the last step the low nibbles of the shift registers hold the operands' top nibbles
  assign ovf_d   = (a_q[3] == b_q[3]) && (s[3] != a_q[3]);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        a_q     <= a;
        b_q     <= b;
        c_q     <= cin;
        idx_q   <= '0;
        state_q <= RUN;
      end
    end else if (state_q == RUN) begin
      a_q   <= a_q >> NIBBLE_W;
      b_q   <= b_q >> NIBBLE_W;
      acc_q <= acc_d;
      c_q   <= co;
      idx_q <= idx_q + 1'b1;
      if (last) begin
        sum_q   <= acc_d;
        cout_q  <= co;
        ovf_q   <= ovf_d;
        state_q <= DONE;
      end
    end else begin
      state_q <= IDLE;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: doc/cla_word_adder_sequencer.md
# cla_word_adder_sequencer

Multi-cycle controller that computes a `4*NIBBLES`-bit sum by time-multiplexing one `four_bit_carry_lookahead_adder` instance, one nibble per clock, LSB nibble first. The block owns operand shift registers, the inter-nibble carry register, a start/done handshake and registered result outputs. It is the sequencing layer the HW datapath uses for word-width additions without replicating the 4-bit adder.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width `W = 4*NIBBLES`; legal range 1..16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; accepted only when state is IDLE.
- `a`  in  W: operand A, sampled on the accepting edge only.
- `b`  in  W: operand B, sampled on the accepting edge only.
- `cin`  in  1: carry-in to nibble 0, sampled on the accepting edge only.
- `busy`  out  1: high while state is RUN.
- `done`  out  1: one-cycle pulse, high while state is DONE.
- `sum`  out  W: registered result; holds until the next result is written.
- `cout`  out  1: carry out of the top nibble; registered.
- `ovf`  out  1: two's-complement overflow, `(a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1])`; registered.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1: latch `a`, `b` into shift registers, load carry reg with `cin`, clear nibble index, go to RUN. IDLE, `start`=0: stay.
- RUN, each edge:
  - Adder inputs are X = A-shift[3:0], Y = B-shift[3:0], Ci = carry reg.
  - Shift A and B right by 4.
  - Shift S into the top nibble of the accumulator.
  - Carry reg <= Co. Index++.
- RUN, on the edge where index == NIBBLES-1: write the final accumulator value, final Co and computed `ovf` into `sum`/`cout`/`ovf`, and go to DONE.
- DONE: go to IDLE unconditionally on the next edge.
- `start` in RUN or DONE is ignored. It is not queued. Operand and `cin` changes outside the accepting edge have no effect.
- `sum`/`cout`/`ovf` do not change during RUN. They change only on the RUN→DONE edge.
- Arithmetic is modulo 2^W. `cout` is the true carry out of bit W-1.
- `NIBBLES`=1 works: exactly one RUN cycle.
- Reset, at any time including mid-RUN:
  - State goes to IDLE and the in-flight operation is discarded.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - Shift registers, accumulator, carry reg and index are cleared.
- `rst` and `start` high on the same edge: reset wins.

## Timing
- Start accepted at edge k: `busy`=1 from edge k through edge k+NIBBLES.
- Result registered at edge k+NIBBLES. `done`=1 for exactly one cycle, from edge k+NIBBLES to edge k+NIBBLES+1.
- Latency from start edge to done: NIBBLES edges.
- Earliest next acceptance: edge k+NIBBLES+2, giving an initiation interval of NIBBLES+2 cycles.
- The adder path is combinational within one cycle: carry reg → adder → carry reg. No multicycle constraints.
- All outputs come directly from registers, including `busy` and `done` from state decode of the state register. There is no combinational path from inputs to outputs.

## Structure
- Package `cla_seq_pkg`:
  - `NIBBLE_W = 4`.
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t`.
- Index width is `$clog2(NIBBLES)`, minimum 1. It is local to the module.
- Exactly one instance of the existing `four_bit_carry_lookahead_adder`, connected by port order (X, Y, Ci, S, Co). It is used unmodified and there is no other sub-module.

## Test plan
With NIBBLES=4:
- 0x0001 + 0x0001, cin=0 → sum=0x0002, cout=0, ovf=0. `done` occurs exactly 4 edges after the start edge and lasts 1 cycle. `busy` is high for 4 cycles.
- 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. This checks the carry rippling through all nibbles via the carry reg.
- 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1. Then 0x8000 + 0x8000 → sum=0x0000, cout=1, ovf=1.
- 0xFFFF + 0xFFFF, cin=1 → sum=0xFFFF, cout=1. `sum` holds the previous result through RUN and changes only on the done edge.
- Second `start` with different operands pulsed during RUN and during DONE → ignored. The first result is unchanged and the next op is accepted only from IDLE.
- Assert `rst` on the 2nd RUN cycle of 0x1234+0x1111 → next cycle `busy`=0, `done`=0, `sum`=0, and no `done` pulse follows. A fresh 0x1234+0x1111 then yields 0x2345.
